// File: rtl/div_param_if.sv
// Request/result bundle for div_param; WIDTH must match the divider instance.
// Handshake: the master raises start_i with operands and holds it high until it has
// consumed the result (ready_o=1); dropping start_i while ready_o is high releases the
// result. annul_i aborts an in-flight operation. dbg_state_o mirrors the divider FSM.
interface div_param_if #(parameter int WIDTH = 32);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               busy_o;
  logic               div_by_zero_o;
  logic [1:0]         dbg_state_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o, div_by_zero_o, dbg_state_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o, div_by_zero_o, dbg_state_o
  );
endinterface

// File: rtl/div_param.sv
// Parametrised radix-2 restoring divider producing {remainder, quotient}.
// Optional leading-zero skip of the dividend under macro DIV_PARAM_EARLY_OUT_EN.
module div_param #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_param_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LP_W = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ZERO = 2'd1,
    S_BUSY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_s1;
  logic               r_s2;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_dbz;

  logic               w_s1;
  logic               w_s2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH-1:0]   w_quo_init;
  logic [CW-1:0]      w_cnt_init;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_quo_sh;
  logic [WIDTH-1:0]   w_quo_fin;
  logic [WIDTH-1:0]   w_rem_fin;

  assign w_s1   = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign w_s2   = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign w_mag1 = w_s1 ? (~bus.opdata1_i + WIDTH'(1)) : bus.opdata1_i;
  assign w_mag2 = w_s2 ? (~bus.opdata2_i + WIDTH'(1)) : bus.opdata2_i;

`ifdef DIV_PARAM_EARLY_OUT_EN
  function automatic logic [CW-1:0] f_clz(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + CW'(1);
      end
    end
    return n;
  endfunction

  logic [CW-1:0] w_lz;
  assign w_lz       = f_clz(w_mag1);
  assign w_quo_init = w_mag1 << w_lz;
  assign w_cnt_init = w_lz;
`else
  assign w_quo_init = w_mag1;
  assign w_cnt_init = '0;
`endif

  // The shifted window is WIDTH+1 bits so a partial remainder above 2^(WIDTH-1)
  // is not lost against large unsigned divisors.
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_quo_sh  = {r_quo[WIDTH-2:0], 1'b0};
  assign w_diff    = w_rem_sh - {1'b0, r_div};
  assign w_quo_fin = (r_s1 ^ r_s2) ? (~r_quo + WIDTH'(1)) : r_quo;
  assign w_rem_fin = r_s1 ? (~r_rem + WIDTH'(1)) : r_rem;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_div      <= '0;
      r_dividend <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_ready    <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            r_s1       <= w_s1;
            r_s2       <= w_s2;
            r_div      <= w_mag2;
            r_dividend <= bus.opdata1_i;
            r_rem      <= '0;
            r_quo      <= w_quo_init;
            if (w_mag2 == '0) begin
              r_cnt   <= '0;
              r_state <= S_ZERO;
            end else begin
              r_cnt   <= w_cnt_init;
              r_state <= S_BUSY;
            end
          end
        end
        S_ZERO: begin
          // Spends two edges so the zero-divisor result lands at start + 2.
          if (bus.annul_i) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_cnt <= CW'(1);
          end else begin
            r_result <= {r_dividend, {WIDTH{1'b1}}};
            r_dbz    <= 1'b1;
            r_ready  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_BUSY: begin
          if (bus.annul_i) begin
            r_state <= S_IDLE;
          end else if (r_cnt == LP_W) begin
            r_result <= {w_rem_fin, w_quo_fin};
            r_ready  <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (!w_diff[WIDTH]) begin
              r_rem <= w_diff[WIDTH-1:0];
              r_quo <= {w_quo_sh[WIDTH-1:1], 1'b1};
            end else begin
              r_rem <= w_rem_sh[WIDTH-1:0];
              r_quo <= w_quo_sh;
            end
          end
        end
        S_DONE: begin
          if (!bus.start_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
            r_dbz    <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.result_o      = r_result;
  assign bus.ready_o       = r_ready;
  assign bus.div_by_zero_o = r_dbz;
  assign bus.busy_o        = (r_state == S_ZERO) || (r_state == S_BUSY);
  assign bus.dbg_state_o   = r_state;

endmodule
